// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;
   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: difference and borrow-out from x - y - bin.
module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bo
);
   assign d  = x ^ y ^ bin;
   assign bo = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock; result and borrow held until the next completion.
// Define SERIAL_SUB_SAT_EN to clamp underflowing results to zero.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             done
);
   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-2:0] res_sh_q, res_sh_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic             cell_d, cell_bo;
   logic [WIDTH-1:0] res_full;

   fs_cell u_fs_cell (
      .x   (a_sh_q[0]),
      .y   (b_sh_q[0]),
      .bin (borrow_q),
      .d   (cell_d),
      .bo  (cell_bo)
   );

   // The newest bit enters at the top; on the last bit this is the whole result.
   assign res_full = {cell_d, res_sh_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      borrow_d = borrow_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d  = SHIFT;
               a_sh_d   = a;
               b_sh_d   = b;
               cnt_d    = '0;
               borrow_d = 1'b0;
            end
         end
         SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_full[WIDTH-1:1];
            borrow_d = cell_bo;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               bout_d  = cell_bo;
`ifdef SERIAL_SUB_SAT_EN
               diff_d  = cell_bo ? '0 : res_full;
`else
               diff_d  = res_full;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
      end
   end

   assign ready = (state_q != SHIFT);
   assign done  = (state_q == DONE);
   assign diff  = diff_q;
   assign bout  = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); expectations follow SERIAL_SUB_SAT_EN when defined.
module tb_serial_subtractor;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       ready, bout, done;
   logic [7:0] diff;

   int tests = 0;
   int fails = 0;

`ifdef SERIAL_SUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .diff  (diff),
      .bout  (bout),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Stimulus only: called #1 after an edge with ready=1; returns edges from accept to done (-1 on timeout).
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         output int n, output logic [7:0] d, output logic bo);
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      forever begin
         @(posedge clk); #1;
         n++;
         if (done) break;
         if (n > 40) begin n = -1; break; end
      end
      d = diff; bo = bout;
   endtask

   task automatic test_reset;
      int n; logic [7:0] d; logic bo;
      start = 1'b1; a = 8'd3; b = 8'd1;
      #2;
      tests++;
      if ({ready, done, diff, bout} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: ready=%b done=%b diff=%0d bout=%b, want 1 0 0 0", ready, done, diff, bout);
      end
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (ready !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL start_in_reset: ready=%b done=%b, want 1 0", ready, done);
      end
      rst = 1'b0;
      run_op(8'd3, 8'd1, n, d, bo);
      tests++;
      if (n !== 8 || d !== 8'd2 || bo !== 1'b0) begin
         fails++;
         $display("FAIL release_start: edges=%0d diff=%0d bout=%b, want 8 2 0", n, d, bo);
      end
   endtask

   task automatic test_basic;
      int n; logic [7:0] d; logic bo;
      run_op(8'd10, 8'd5, n, d, bo);
      tests++;
      if (n !== 8 || d !== 8'd5 || bo !== 1'b0) begin
         fails++;
         $display("FAIL basic_10_5: edges=%0d diff=%0d bout=%b, want 8 5 0", n, d, bo);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL done_pulse_width: done=%b ready=%b, want 0 1", done, ready);
      end
      a = 8'd200; b = 8'd7;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (diff !== 8'd5 || bout !== 1'b0) begin
         fails++;
         $display("FAIL hold_idle: diff=%0d bout=%b, want 5 0", diff, bout);
      end
      run_op(8'd128, 8'd127, n, d, bo);
      tests++;
      if (n !== 8 || d !== 8'd1 || bo !== 1'b0) begin
         fails++;
         $display("FAIL basic_128_127: edges=%0d diff=%0d bout=%b, want 8 1 0", n, d, bo);
      end
      run_op(8'd77, 8'd77, n, d, bo);
      tests++;
      if (n !== 8 || d !== 8'd0 || bo !== 1'b0) begin
         fails++;
         $display("FAIL equal_77: edges=%0d diff=%0d bout=%b, want 8 0 0", n, d, bo);
      end
   endtask

   task automatic test_underflow;
      int n; logic [7:0] d; logic bo;
      run_op(8'd5, 8'd10, n, d, bo);
      tests++;
      if (n !== 8 || d !== (SAT ? 8'd0 : 8'd251) || bo !== 1'b1) begin
         fails++;
         $display("FAIL under_5_10: edges=%0d diff=%0d bout=%b, want 8 %0d 1", n, d, bo, SAT ? 0 : 251);
      end
      run_op(8'd0, 8'd255, n, d, bo);
      tests++;
      if (n !== 8 || d !== (SAT ? 8'd0 : 8'd1) || bo !== 1'b1) begin
         fails++;
         $display("FAIL under_0_255: edges=%0d diff=%0d bout=%b, want 8 %0d 1", n, d, bo, SAT ? 0 : 1);
      end
   endtask

   task automatic test_back_to_back;
      int n1, n2;
      logic [7:0] d1;
      logic bo1;
      logic held;
      a = 8'd255; b = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      a = 8'd50; b = 8'd50;
      n1 = 0;
      forever begin
         @(posedge clk); #1;
         n1++;
         if (done || n1 > 40) break;
      end
      d1 = diff; bo1 = bout;
      n2 = 0; held = 1'b1;
      forever begin
         @(posedge clk); #1;
         n2++;
         if (done || n2 > 40) break;
         if (diff !== 8'd254) held = 1'b0;
      end
      start = 1'b0;
      tests++;
      if (n1 !== 8 || d1 !== 8'd254 || bo1 !== 1'b0) begin
         fails++;
         $display("FAIL b2b_first: edges=%0d diff=%0d bout=%b, want 8 254 0", n1, d1, bo1);
      end
      tests++;
      if (n2 !== 9 || diff !== 8'd0 || bout !== 1'b0) begin
         fails++;
         $display("FAIL b2b_second: gap=%0d diff=%0d bout=%b, want 9 0 0", n2, diff, bout);
      end
      tests++;
      if (held !== 1'b1) begin
         fails++;
         $display("FAIL b2b_hold: diff changed before completion, want 254 held");
      end
      @(posedge clk); #1;
   endtask

   task automatic test_busy_start;
      int n, pulses;
      logic [7:0] d; logic bo;
      a = 8'd100; b = 8'd200; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; pulses = 0;
      forever begin
         @(posedge clk); #1;
         n++;
         if (n == 3) begin a = 8'd99; b = 8'd1; start = 1'b1; end
         else start = 1'b0;
         if (done || n > 40) break;
      end
      d = diff; bo = bout;
      tests++;
      if (n !== 8 || d !== (SAT ? 8'd0 : 8'd156) || bo !== 1'b1) begin
         fails++;
         $display("FAIL busy_result: edges=%0d diff=%0d bout=%b, want 8 %0d 1", n, d, bo, SAT ? 0 : 156);
      end
      repeat (12) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      tests++;
      if (pulses !== 0 || diff !== d) begin
         fails++;
         $display("FAIL busy_single_done: extra pulses=%0d diff=%0d, want 0 %0d", pulses, diff, d);
      end
   endtask

   task automatic test_reset_mid;
      int n, pulses;
      logic [7:0] d; logic bo;
      a = 8'd240; b = 8'd30; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({ready, done, diff, bout} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL mid_reset_async: ready=%b done=%b diff=%0d bout=%b, want 1 0 0 0", ready, done, diff, bout);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      tests++;
      if (pulses !== 0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset_abandon: pulses=%0d ready=%b, want 0 1", pulses, ready);
      end
      run_op(8'd240, 8'd30, n, d, bo);
      tests++;
      if (n !== 8 || d !== 8'd210 || bo !== 1'b0) begin
         fails++;
         $display("FAIL after_reset_op: edges=%0d diff=%0d bout=%b, want 8 210 0", n, d, bo);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_back_to_back();
      test_busy_start();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled only when ready=1.
REQ-005 a  input  WIDTH  minuend, captured on the accept edge.
REQ-006 b  input  WIDTH  subtrahend, captured on the accept edge.
REQ-007 ready  output  1  high in IDLE and DONE, when a new start is accepted.
REQ-008 diff  output  WIDTH  registered result a-b mod 2^WIDTH (saturated when so configured); held until the next completion.
REQ-009 bout  output  1  registered borrow-out, 1 when a<b unsigned; held with diff.
REQ-010 done  output  1  one-cycle pulse marking valid new diff/bout.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 Accept edge is a rising clk edge with start=1 and ready=1: it captures a, b, clears the internal borrow and bit counter, and enters SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit, LSB first: d = ai^bi^borrow, borrow' = (~ai&bi)|(~(ai^bi)&borrow); counter increments.
REQ-014 The edge processing bit WIDTH-1 SHALL load diff and bout, enter DONE, and raise done for exactly that following cycle.
REQ-015 Latency: done SHALL be high in the cycle after the WIDTH-th edge following the accept edge (8 edges for WIDTH=8).
REQ-016 In DONE with start=0, the next edge SHALL return to IDLE; with start=1, that edge is an accept edge (back-to-back, no idle gap).
REQ-017 start while in SHIFT SHALL be ignored and the running operation is unaffected; a, b changes during SHIFT SHALL have no effect.
REQ-018 diff and bout SHALL change only on the completion edge; between completions they hold the last result.
REQ-019 Equal operands SHALL give diff=0, bout=0; a=0, b=2^WIDTH-1 SHALL give diff=1, bout=1 (unsaturated).

Reset
REQ-020 rst=1 SHALL immediately force IDLE, ready=1, done=0, diff=0, bout=0, counter and borrow cleared, independent of clk.
REQ-021 Reset asserted mid-SHIFT SHALL abandon the operation with no done pulse; after release the block accepts the next start normally.
REQ-022 start high during or coincident with reset release SHALL not be accepted until the first edge with rst=0.

Configuration
REQ-023 Macro SERIAL_SUB_SAT_EN SHALL control saturation.
REQ-024 With SERIAL_SUB_SAT_EN defined, a completion with borrow=1 SHALL load diff=0 while bout=1 still reports the underflow.
REQ-025 Without SERIAL_SUB_SAT_EN, diff SHALL be the wrapped modulo-2^WIDTH result; no saturation logic is present.

Structure
REQ-026 A shared package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the default-width constant 8.
REQ-027 The one-bit full-subtractor equations of REQ-013 SHALL live in sub-module fs_cell (inputs x, y, bin; outputs d, bo), instantiated once.
REQ-028 Operand and result shift registers and the counter (width clog2(WIDTH)+1) SHALL be in serial_subtractor itself.

Verification
REQ-029 Basic: a=10, b=5, start pulse -> done 8 edges after accept, diff=5, bout=0; a=128, b=127 -> diff=1, bout=0.
REQ-030 Underflow: a=5, b=10 -> diff=251, bout=1 (SAT_EN: diff=0, bout=1); a=0, b=255 -> diff=1, bout=1 (SAT_EN: 0, 1).
REQ-031 Back-to-back: start held high, pairs (255,1) then (50,50) -> done pulses 9 edges apart, diff=254 then 0, bout=0 both.
REQ-032 Busy start: start pulsed with a=99, b=1 three edges into (100,200) -> single done, diff=156, bout=1; 99-1 never produced.
REQ-033 Reset mid-op: rst asserted 4 edges after accepting (240,30) -> outputs 0, ready=1 asynchronously, no done; next (240,30) -> diff=210, bout=0.
